// File: rtl/act_pingpong_buffer.sv
// Double-buffered activation store: the producer fills one bank while the consumer reads the other.
// Optional macro ACT_RELU_EN rectifies write data (negative -> 0) before it is stored.
module act_pingpong_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_commit,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_avail,
  input  logic                     rd_release,
  output logic [1:0]               banks_full,
  output logic                     err_oob
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [1:0]               r_full;
  logic                     r_w_sel;
  logic                     r_r_sel;
  logic signed [DATA_W-1:0] r_rd_data;
  logic                     r_rd_valid;
  logic                     r_err_oob;
  logic signed [DATA_W-1:0] r_mem [2][DEPTH];

  logic                     w_wr_in_range;
  logic                     w_rd_in_range;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [IDX_W-1:0]         w_rd_idx;
  logic                     w_wr_do;
  logic                     w_commit_do;
  logic                     w_rd_do;
  logic                     w_release_do;
  logic [1:0]               w_full_nxt;
  logic signed [DATA_W-1:0] w_wr_store;

  assign wr_ready   = !r_full[r_w_sel];
  assign rd_avail   = r_full[r_r_sel];
  assign banks_full = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign err_oob    = r_err_oob;

  assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
  assign w_wr_idx      = wr_addr[IDX_W-1:0];
  assign w_rd_idx      = rd_addr[IDX_W-1:0];
  assign w_wr_do       = wr_en && wr_ready && w_wr_in_range;
  assign w_commit_do   = wr_commit && wr_ready;
  assign w_rd_do       = rd_en && rd_avail;
  assign w_release_do  = rd_release && rd_avail;

`ifdef ACT_RELU_EN
  assign w_wr_store = wr_data[DATA_W-1] ? '0 : wr_data;
`else
  assign w_wr_store = wr_data;
`endif

  // Commit and release can never hit the same bank: commit needs it empty, release needs it full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_full_nxt = r_full;
    if (w_commit_do)  w_full_nxt[r_w_sel] = 1'b1;
    if (w_release_do) w_full_nxt[r_r_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full     <= '0;
      r_w_sel    <= 1'b0;
      r_r_sel    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err_oob  <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_rd_valid <= w_rd_do;
      if (w_commit_do)  r_w_sel <= !r_w_sel;
      if (w_release_do) r_r_sel <= !r_r_sel;
      if (w_rd_do) r_rd_data <= w_rd_in_range ? r_mem[r_r_sel][w_rd_idx] : '0;
      if ((w_rd_do && !w_rd_in_range) || (wr_en && !w_wr_in_range)) r_err_oob <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; a cleared RAM costs a reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (w_wr_do) r_mem[r_w_sel][w_wr_idx] <= w_wr_store;
  end

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Self-checking bench for act_pingpong_buffer: directed steps plus random traffic against
// a bank-queue reference model (commit/release counters, no knowledge of the RTL encoding).
module tb_act_pingpong_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_commit;
  logic                     wr_ready;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     rd_avail;
  logic                     rd_release;
  logic [1:0]               banks_full;
  logic                     err_oob;

  act_pingpong_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_avail(rd_avail), .rd_release(rd_release),
    .banks_full(banks_full), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: banks are committed and released strictly in alternation, so the
  // write bank is (commits mod 2), the read bank is (releases mod 2), occupancy is the difference.
  int                       commits  = 0;
  int                       releases = 0;
  logic signed [DATA_W-1:0] mm [2][DEPTH];
  bit                       mv [2][DEPTH];
  logic signed [DATA_W-1:0] exp_data  = '0;
  bit                       exp_known = 1'b1;
  bit                       exp_valid = 1'b0;
  bit                       exp_err   = 1'b0;

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] d);
`ifdef ACT_RELU_EN
    return (d < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit rst, input bit we, input int wa, input logic [DATA_W-1:0] wd,
                      input bit wc, input bit re, input int ra, input bit rr);
    int cnt;
    int wb;
    int rb;
    bit ready;
    bit avail;
    reset      = rst;
    wr_en      = we;
    wr_addr    = ADDR_W'(wa);
    wr_data    = wd;
    wr_commit  = wc;
    rd_en      = re;
    rd_addr    = ADDR_W'(ra);
    rd_release = rr;
    @(posedge clk);
    #1;
    if (rst) begin
      commits   = 0;
      releases  = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_known = 1'b1;
      exp_err   = 1'b0;
    end else begin
      cnt   = commits - releases;
      wb    = commits % 2;
      rb    = releases % 2;
      ready = (cnt < 2);
      avail = (cnt > 0);
      exp_valid = re && avail;
      if (re && avail) begin
        if (ra < DEPTH) begin
          exp_data  = mm[rb][ra];
          exp_known = mv[rb][ra];
        end else begin
          exp_data  = '0;
          exp_known = 1'b1;
          exp_err   = 1'b1;
        end
      end
      if (we && wa >= DEPTH) exp_err = 1'b1;
      if (we && ready && wa < DEPTH) begin
        mm[wb][wa] = relu(wd);
        mv[wb][wa] = 1'b1;
      end
      if (wc && ready) commits++;
      if (rr && avail) releases++;
    end
    cnt = commits - releases;
    check("wr_ready",   DATA_W'(wr_ready),   DATA_W'(cnt < 2));
    check("rd_avail",   DATA_W'(rd_avail),   DATA_W'(cnt > 0));
    check("banks_full", DATA_W'(banks_full), DATA_W'(cnt));
    check("rd_valid",   DATA_W'(rd_valid),   DATA_W'(exp_valid));
    check("err_oob",    DATA_W'(err_oob),    DATA_W'(exp_err));
    if (exp_known) check("rd_data", rd_data, exp_data);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  logic signed [DATA_W-1:0] exp_c;

  initial begin
    // Reset state
    step(1, 0, 0, '0, 0, 0, 0, 0);
    idle();

    // Fill bank0 with addr-32; commit on the last write (write lands before commit)
    for (int a = 0; a < DEPTH; a++)
      step(0, 1, a, DATA_W'(a - 32), (a == DEPTH - 1), 0, 0, 0);
    check("bank0_committed", DATA_W'(banks_full), 1);
    step(0, 0, 0, '0, 0, 1, 5, 0);
`ifdef ACT_RELU_EN
    exp_c = 0;
`else
    exp_c = -27;
`endif
    check("read_addr5", rd_data, exp_c);
    check("read_addr5_valid", DATA_W'(rd_valid), 1);

    // Fill bank1 and commit: both banks full, a further write is dropped
    for (int a = 0; a < DEPTH; a++)
      step(0, 1, a, DATA_W'($urandom), (a == DEPTH - 1), 0, 0, 0);
    check("both_full", DATA_W'(banks_full), 2);
    check("not_ready", DATA_W'(wr_ready), 0);
    step(0, 1, 0, 32'h7, 0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0, 1);          // release bank0
    step(0, 0, 0, '0, 1, 0, 0, 0);          // recommit bank0 without rewriting
    step(0, 0, 0, '0, 0, 1, 3, 0);          // read bank1
    step(0, 0, 0, '0, 0, 0, 0, 1);          // release bank1
    step(0, 0, 0, '0, 0, 1, 0, 0);          // read bank0 addr0
`ifdef ACT_RELU_EN
    exp_c = 0;
`else
    exp_c = -32;
`endif
    check("dropped_write_bank0", rd_data, exp_c);

    // Simultaneous commit (bank1) and release (bank0) with one bank full
    step(0, 1, 0, 32'sd55, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 1);
    check("swap_banks_full", DATA_W'(banks_full), 1);
    check("swap_rd_avail", DATA_W'(rd_avail), 1);
    check("swap_wr_ready", DATA_W'(wr_ready), 1);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    check("swap_read_bank1", rd_data, 55);

    // Read and release with nothing available
    step(0, 0, 0, '0, 0, 0, 0, 1);
    step(0, 0, 0, '0, 0, 1, 7, 1);
    check("noavail_valid", DATA_W'(rd_valid), 0);
    check("noavail_hold", rd_data, 55);
    check("noavail_full", DATA_W'(banks_full), 0);

    // Out-of-range read, then sticky error until reset
    step(0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, DEPTH, 0);
    check("oob_rd_data", rd_data, 0);
    check("oob_rd_err", DATA_W'(err_oob), 1);
    repeat (3) idle();
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(0, 1, 100, 32'h1234, 0, 0, 0, 0);
    check("oob_wr_err", DATA_W'(err_oob), 1);
    repeat (3) idle();
    step(1, 0, 0, '0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int wa;
      int ra;
      wa = ($urandom_range(15) == 0) ? DEPTH + int'($urandom_range(200)) : int'($urandom_range(DEPTH - 1));
      ra = ($urandom_range(15) == 0) ? DEPTH + int'($urandom_range(200)) : int'($urandom_range(DEPTH - 1));
      step(0, ($urandom_range(9) < 6), wa, DATA_W'($urandom), ($urandom_range(19) == 0),
           ($urandom_range(1) == 1), ra, ($urandom_range(19) == 0));
    end

    // Reset during a back-to-back read burst
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    for (int a = 0; a < 4; a++) step(0, 0, 0, '0, 0, 1, a, 0);
    check("burst_valid", DATA_W'(rd_valid), 1);
    step(1, 0, 0, '0, 0, 1, 4, 0);
    check("rst_squash_valid", DATA_W'(rd_valid), 0);
    check("rst_banks_full", DATA_W'(banks_full), 0);
    check("rst_wr_ready", DATA_W'(wr_ready), 1);
    check("rst_rd_avail", DATA_W'(rd_avail), 0);
    check("rst_err", DATA_W'(err_oob), 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
